// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer
// Sits between InstructionFetcher and decode. Each fetched 64-bit word is
// split into two 32-bit instructions, each tagged with its PC, and the
// instructions are queued in a small circular FIFO. The head of the FIFO is
// offered to decode through a valid/ready handshake. While a redirect flush
// is active the queue is held empty and returned words are acknowledged but
// dropped.
module fetch_decode_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetcher_done,
  input  logic [63:0]              instruction_out,
  input  logic [63:0]              address_out,
  output logic                     fetch_enable,
  output logic                     fetch_ack,
  input  logic                     flush,
  output logic                     decode_valid,
  output logic [31:0]              decode_instr,
  output logic [63:0]              decode_pc,
  input  logic                     decode_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_p1;
  logic          armed;

  logic          aligned;
  logic [CW-1:0] need;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic          take;
  logic          capture;
  logic          discard;
  logic          pop;
  logic [63:0]   base_pc;
  logic          unused_addr_bits;

  // Word addresses are always 4-byte aligned, so the two low bits carry nothing.
  assign unused_addr_bits = ^address_out[1:0];

  // Head of the queue is presented combinationally; a flush hides it at once.
  assign decode_valid = (count != '0) && !flush;
  assign decode_instr = instr_mem[rd_ptr];
  assign decode_pc    = pc_mem[rd_ptr];

  // Only let the fetcher start when a whole aligned word is guaranteed to fit.
  assign fetch_enable = !flush && armed && !fetcher_done && (free_slots >= CW'(2));

  // Decide how many entries the held word needs and whether it is taken,
  // dropped or left waiting this cycle. Space is judged on the current count,
  // so a same-cycle pop never makes room for a push.
  always_comb begin
    aligned    = !address_out[2];
    need       = aligned ? CW'(2) : CW'(1);
    base_pc    = {address_out[63:3], 3'b000};
    free_slots = DEPTH_C - count;
    take       = armed && fetcher_done;
    capture    = take && !flush && (free_slots >= need);
    discard    = take && flush;
    pop        = decode_valid && decode_ready;
    push_n     = capture ? need : '0;
    pop_n      = pop ? CW'(1) : '0;
    wr_ptr_p1  = wr_ptr + AW'(1);
  end

  // Pointers, occupancy, the re-arm flag and the one-cycle acknowledge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      armed     <= 1'b1;
      fetch_ack <= 1'b0;
    end else begin
      fetch_ack <= capture || discard;
      if (capture || discard) begin
        armed <= 1'b0;
      end else if (!fetcher_done) begin
        armed <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (capture) begin
          wr_ptr <= wr_ptr + push_n[AW-1:0];
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + push_n - pop_n;
      end
    end
  end

  // Entry storage: an aligned word fills two slots, a word fetched from the
  // upper half fills only one with the upper instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (capture) begin
      if (aligned) begin
        pc_mem[wr_ptr]       <= base_pc;
        instr_mem[wr_ptr]    <= instruction_out[31:0];
        pc_mem[wr_ptr_p1]    <= base_pc | 64'h4;
        instr_mem[wr_ptr_p1] <= instruction_out[63:32];
      end else begin
        pc_mem[wr_ptr]       <= base_pc | 64'h4;
        instr_mem[wr_ptr]    <= instruction_out[63:32];
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer
// Directed bench for fetch_decode_buffer: a table of per-cycle vectors for
// capture, misaligned capture and backpressure, then hand-written sequences
// for wrap-around streaming, flush and asynchronous reset.
module tb_fetch_decode_buffer;

  logic        clk;
  logic        reset;
  logic        fetcher_done;
  logic [63:0] instruction_out;
  logic [63:0] address_out;
  logic        fetch_enable;
  logic        fetch_ack;
  logic        flush;
  logic        decode_valid;
  logic [31:0] decode_instr;
  logic [63:0] decode_pc;
  logic        decode_ready;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        done;
    logic [63:0] addr;
    logic [63:0] word;
    logic        fl;
    logic        ready;
    logic        exp_ack;
    logic        exp_en;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[24];

  fetch_decode_buffer #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetcher_done    (fetcher_done),
    .instruction_out (instruction_out),
    .address_out     (address_out),
    .fetch_enable    (fetch_enable),
    .fetch_ack       (fetch_ack),
    .flush           (flush),
    .decode_valid    (decode_valid),
    .decode_instr    (decode_instr),
    .decode_pc       (decode_pc),
    .decode_ready    (decode_ready),
    .count           (count)
  );

  // Free-running clock: rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic d, input logic [63:0] a, input logic [63:0] w,
                              input logic f, input logic r, input logic ack, input logic en,
                              input logic v, input logic [2:0] c, input logic [63:0] pc,
                              input logic [31:0] ins);
    vec_t t;
    t.done = d; t.addr = a; t.word = w; t.fl = f; t.ready = r;
    t.exp_ack = ack; t.exp_en = en; t.exp_valid = v; t.exp_count = c;
    t.exp_pc = pc; t.exp_instr = ins;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input vec_t t);
    fetcher_done    = t.done;
    address_out     = t.addr;
    instruction_out = t.word;
    flush           = t.fl;
    decode_ready    = t.ready;
  endtask

  // Hold a word until it is acknowledged, then drop done long enough to re-arm.
  task automatic push_word(input logic [63:0] a, input logic [63:0] w);
    logic seen;
    seen            = 1'b0;
    fetcher_done    = 1'b1;
    address_out     = a;
    instruction_out = w;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (fetch_ack) seen = 1'b1;
    end
    check_output("push_ack_seen", 64'(seen), 64'd1);
    @(negedge clk);
    fetcher_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int w;
    int k;
    logic low_next;

    reset           = 1'b0;
    fetcher_done    = 1'b0;
    instruction_out = '0;
    address_out     = '0;
    flush           = 1'b0;
    decode_ready    = 1'b0;

    // Cycle vectors: inputs for the cycle, then outputs expected during it.
    vecs[0]  = mk(0, 64'h0,    64'h0,                   0, 0, 0, 1, 0, 3'd0, 64'h0,    32'h0);
    vecs[1]  = mk(1, 64'h1000, 64'hBBBBBBBB_AAAAAAAA,   0, 0, 0, 0, 0, 3'd0, 64'h0,    32'h0);
    vecs[2]  = mk(1, 64'h1000, 64'hBBBBBBBB_AAAAAAAA,   0, 0, 1, 0, 1, 3'd2, 64'h1000, 32'hAAAAAAAA);
    vecs[3]  = mk(1, 64'h1000, 64'hBBBBBBBB_AAAAAAAA,   0, 0, 0, 0, 1, 3'd2, 64'h1000, 32'hAAAAAAAA);
    vecs[4]  = mk(1, 64'h1000, 64'hBBBBBBBB_AAAAAAAA,   0, 0, 0, 0, 1, 3'd2, 64'h1000, 32'hAAAAAAAA);
    vecs[5]  = mk(0, 64'h0,    64'h0,                   0, 1, 0, 0, 1, 3'd2, 64'h1000, 32'hAAAAAAAA);
    vecs[6]  = mk(0, 64'h0,    64'h0,                   0, 0, 0, 1, 1, 3'd1, 64'h1004, 32'hBBBBBBBB);
    vecs[7]  = mk(0, 64'h0,    64'h0,                   0, 1, 0, 1, 1, 3'd1, 64'h1004, 32'hBBBBBBBB);
    vecs[8]  = mk(1, 64'h2004, 64'h22222222_11111111,   0, 0, 0, 0, 0, 3'd0, 64'h0,    32'h0);
    vecs[9]  = mk(0, 64'h0,    64'h0,                   0, 0, 1, 0, 1, 3'd1, 64'h2004, 32'h22222222);
    vecs[10] = mk(1, 64'h3000, 64'h44444444_33333333,   0, 0, 0, 0, 1, 3'd1, 64'h2004, 32'h22222222);
    vecs[11] = mk(0, 64'h0,    64'h0,                   0, 0, 1, 0, 1, 3'd3, 64'h2004, 32'h22222222);
    vecs[12] = mk(1, 64'h4000, 64'h66666666_55555555,   0, 0, 0, 0, 1, 3'd3, 64'h2004, 32'h22222222);
    vecs[13] = mk(1, 64'h4000, 64'h66666666_55555555,   0, 0, 0, 0, 1, 3'd3, 64'h2004, 32'h22222222);
    vecs[14] = mk(1, 64'h4000, 64'h66666666_55555555,   0, 1, 0, 0, 1, 3'd3, 64'h2004, 32'h22222222);
    vecs[15] = mk(1, 64'h4000, 64'h66666666_55555555,   0, 0, 0, 0, 1, 3'd2, 64'h3000, 32'h33333333);
    vecs[16] = mk(0, 64'h0,    64'h0,                   0, 0, 1, 0, 1, 3'd4, 64'h3000, 32'h33333333);
    vecs[17] = mk(0, 64'h0,    64'h0,                   0, 0, 0, 0, 1, 3'd4, 64'h3000, 32'h33333333);
    vecs[18] = mk(0, 64'h0,    64'h0,                   0, 1, 0, 0, 1, 3'd4, 64'h3000, 32'h33333333);
    vecs[19] = mk(0, 64'h0,    64'h0,                   0, 1, 0, 0, 1, 3'd3, 64'h3004, 32'h44444444);
    vecs[20] = mk(0, 64'h0,    64'h0,                   0, 1, 0, 1, 1, 3'd2, 64'h4000, 32'h55555555);
    vecs[21] = mk(0, 64'h0,    64'h0,                   0, 1, 0, 1, 1, 3'd1, 64'h4004, 32'h66666666);
    vecs[22] = mk(0, 64'h0,    64'h0,                   0, 1, 0, 1, 0, 3'd0, 64'h0,    32'h0);
    vecs[23] = mk(0, 64'h0,    64'h0,                   0, 0, 0, 1, 0, 3'd0, 64'h0,    32'h0);

    // Values held in reset.
    #12;
    check_output("rst_count",  64'(count), 64'd0);
    check_output("rst_valid",  64'(decode_valid), 64'd0);
    check_output("rst_ack",    64'(fetch_ack), 64'd0);
    check_output("rst_pc",     decode_pc, 64'd0);
    check_output("rst_instr",  64'(decode_instr), 64'd0);

    @(negedge clk);
    reset = 1'b1;

    // Table: aligned capture, no double capture, misaligned capture, backpressure, drain.
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i]);
      #2;
      check_output($sformatf("v%0d_ack", i),   64'(fetch_ack),    64'(vecs[i].exp_ack));
      check_output($sformatf("v%0d_en", i),    64'(fetch_enable), 64'(vecs[i].exp_en));
      check_output($sformatf("v%0d_valid", i), 64'(decode_valid), 64'(vecs[i].exp_valid));
      check_output($sformatf("v%0d_count", i), 64'(count),        64'(vecs[i].exp_count));
      if (vecs[i].exp_valid) begin
        check_output($sformatf("v%0d_pc", i),    decode_pc,          vecs[i].exp_pc);
        check_output($sformatf("v%0d_instr", i), 64'(decode_instr),  64'(vecs[i].exp_instr));
      end
      @(negedge clk);
    end

    // Wrap-around: six aligned words streamed with decode always ready.
    decode_ready = 1'b1;
    w = 0;
    k = 0;
    low_next = 1'b0;
    for (int cyc = 0; cyc < 300 && k < 12; cyc++) begin
      if (low_next) begin
        fetcher_done = 1'b0;
        low_next = 1'b0;
      end else if (w < 6) begin
        fetcher_done    = 1'b1;
        address_out     = 64'h8000 + 64'(w * 8);
        instruction_out = {32'h1000_0000 + 32'(2 * w + 1), 32'h1000_0000 + 32'(2 * w)};
      end else begin
        fetcher_done = 1'b0;
      end
      #2;
      if (fetch_ack) begin
        w++;
        low_next = 1'b1;
      end
      if (decode_valid) begin
        check_output($sformatf("wrap_pc%0d", k),    decode_pc,         64'h8000 + 64'(k * 4));
        check_output($sformatf("wrap_instr%0d", k), 64'(decode_instr), 64'(32'h1000_0000 + 32'(k)));
        k++;
      end
      @(negedge clk);
    end
    fetcher_done = 1'b0;
    check_output("wrap_total", 64'(k), 64'd12);
    @(negedge clk);
    #2;
    check_output("wrap_empty", 64'(count), 64'd0);
    @(negedge clk);

    // Flush with a full queue; a word returns during the flush and is dropped.
    decode_ready = 1'b0;
    push_word(64'hA000, 64'hA1A1A1A1_A0A0A0A0);
    push_word(64'hA008, 64'hA3A3A3A3_A2A2A2A2);
    #2;
    check_output("fl_pre_count", 64'(count), 64'd4);
    @(negedge clk);
    flush = 1'b1; decode_ready = 1'b1;
    #2;
    check_output("fl1_valid", 64'(decode_valid), 64'd0);
    check_output("fl1_en",    64'(fetch_enable), 64'd0);
    @(negedge clk);
    fetcher_done = 1'b1; address_out = 64'h9000; instruction_out = 64'h99999999_88888888;
    #2;
    check_output("fl2_valid", 64'(decode_valid), 64'd0);
    check_output("fl2_count", 64'(count), 64'd0);
    check_output("fl2_ack",   64'(fetch_ack), 64'd0);
    @(negedge clk);
    #2;
    check_output("fl3_valid", 64'(decode_valid), 64'd0);
    check_output("fl3_ack",   64'(fetch_ack), 64'd1);
    check_output("fl3_count", 64'(count), 64'd0);
    @(negedge clk);
    flush = 1'b0; fetcher_done = 1'b0; decode_ready = 1'b0;
    #2;
    check_output("fl4_valid", 64'(decode_valid), 64'd0);
    check_output("fl4_count", 64'(count), 64'd0);
    check_output("fl4_ack",   64'(fetch_ack), 64'd0);
    check_output("fl4_en",    64'(fetch_enable), 64'd0);
    @(negedge clk);
    #2;
    check_output("fl5_en",    64'(fetch_enable), 64'd1);
    check_output("fl5_count", 64'(count), 64'd0);
    @(negedge clk);

    // Asynchronous reset while three entries are queued and an ack is pending.
    push_word(64'hB000, 64'hB1B1B1B1_B0B0B0B0);
    fetcher_done = 1'b1; address_out = 64'hC004; instruction_out = 64'hC1C1C1C1_C0C0C0C0;
    @(negedge clk);
    #2;
    check_output("ar_pre_count", 64'(count), 64'd3);
    check_output("ar_pre_ack",   64'(fetch_ack), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_output("ar_count", 64'(count), 64'd0);
    check_output("ar_valid", 64'(decode_valid), 64'd0);
    check_output("ar_ack",   64'(fetch_ack), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check_output("ar_recap_count", 64'(count), 64'd1);
    check_output("ar_recap_ack",   64'(fetch_ack), 64'd1);
    check_output("ar_recap_pc",    decode_pc, 64'hC004);
    check_output("ar_recap_instr", 64'(decode_instr), 64'hC1C1C1C1);
    fetcher_done = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
